// File: rtl/alu_pkg.sv
// Shared definitions for the ALU command path: opcodes, feeder FSM states,
// the packed command word and the ALU pipeline latency.
package alu_pkg;

   localparam int ALU_LAT = 2;
   localparam int CMD_W   = 10;

   typedef enum logic [1:0] {
      OP_ADD = 2'd0,
      OP_MUL = 2'd1,
      OP_SUB = 2'd2,
      OP_AND = 2'd3
   } op_t;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2
   } state_t;

   typedef struct packed {
      op_t        op;
      logic [3:0] a;
      logic [3:0] b;
   } cmd_t;

endpackage

// File: rtl/alu_cmd_feeder_if.sv
// Command handshake into the feeder: producer drives valid and payload,
// the feeder answers with ready.
interface alu_cmd_feeder_if;

   logic       in_valid;
   logic       in_ready;
   logic [3:0] in_a;
   logic [3:0] in_b;
   logic [1:0] in_op;

   modport master (output in_valid, output in_a, output in_b, output in_op, input in_ready);
   modport slave  (input in_valid, input in_a, input in_b, input in_op, output in_ready);

endinterface

// File: rtl/alu_cmd_fifo.sv
// DEPTH-deep synchronous FIFO with occupancy count, sync flush and async reset.
// The caller only pushes when not full and only pops when not empty.
module alu_cmd_fifo #(
   parameter int DEPTH  = 8,
   parameter int ADDR_W = 3,
   parameter int WIDTH  = 10
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              push,
   input  logic [WIDTH-1:0]  wdata,
   input  logic              pop,
   output logic [WIDTH-1:0]  rdata,
   output logic [ADDR_W:0]   count
);

   logic [WIDTH-1:0]  mem [DEPTH];
   logic [ADDR_W-1:0] wptr;
   logic [ADDR_W-1:0] rptr;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else if (flush) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else begin
         if (push) wptr <= wptr + 1'b1;
         if (pop)  rptr <= rptr + 1'b1;
         unique case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Storage carries no reset; only pointers and count define validity.
   always_ff @(posedge clk) begin
      if (push && !flush) mem[wptr] <= wdata;
   end

   assign rdata = mem[rptr];

endmodule

// File: rtl/alu_cmd_feeder.sv
// Command feeder for alu_seq: FIFO-buffered issue with a latency-matched result strobe.
// Optional ALU_FEED_TAG_EN adds an opcode tag pipe driving res_op.
module alu_cmd_feeder
   import alu_pkg::*;
#(
   parameter int DEPTH   = 8,
   parameter int ADDR_W  = 3,
   parameter int ALU_LAT = alu_pkg::ALU_LAT
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              enable,
   alu_cmd_feeder_if.slave   in_if,
   output logic [3:0]        alu_a,
   output logic [3:0]        alu_b,
   output logic [1:0]        alu_op,
   input  logic [7:0]        alu_res,
   output logic              res_valid,
   output logic [7:0]        res_data,
`ifdef ALU_FEED_TAG_EN
   output logic [1:0]        res_op,
`endif
   output logic [ADDR_W:0]   count,
   output logic              busy
);

   localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);

   state_t              state;
   cmd_t                wcmd;
   cmd_t                head;
   logic                push;
   logic                pop;
   logic [ADDR_W:0]     cnt_nxt;
   logic [ALU_LAT-1:0]  tag_p;
   logic [ALU_LAT-1:0]  tag_nxt;
`ifdef ALU_FEED_TAG_EN
   logic [1:0]          op_p [ALU_LAT];
`endif

   assign in_if.in_ready = (count < FULL_CNT);
   assign push    = in_if.in_valid && in_if.in_ready && !flush;
   assign pop     = (state == ST_RUN) && enable && (count != '0) && !flush;
   assign cnt_nxt = count + (ADDR_W+1)'(push) - (ADDR_W+1)'(pop);
   assign tag_nxt = (tag_p << 1) | ALU_LAT'(pop);

   assign wcmd.op = op_t'(in_if.in_op);
   assign wcmd.a  = in_if.in_a;
   assign wcmd.b  = in_if.in_b;

   alu_cmd_fifo #(
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W),
      .WIDTH  (CMD_W)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .flush (flush),
      .push  (push),
      .wdata (wcmd),
      .pop   (pop),
      .rdata (head),
      .count (count)
   );

   // Issue stage: pop head into the ALU operand registers; tag bit marks a real command.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= ST_IDLE;
         alu_a     <= '0;
         alu_b     <= '0;
         alu_op    <= '0;
         tag_p     <= '0;
         res_valid <= 1'b0;
`ifdef ALU_FEED_TAG_EN
         for (int i = 0; i < ALU_LAT; i++) op_p[i] <= '0;
         res_op    <= '0;
`endif
      end else if (flush) begin
         state     <= ST_IDLE;
         tag_p     <= '0;
         res_valid <= 1'b0;
`ifdef ALU_FEED_TAG_EN
         for (int i = 0; i < ALU_LAT; i++) op_p[i] <= '0;
         res_op    <= '0;
`endif
      end else begin
         tag_p     <= tag_nxt;
         res_valid <= tag_p[ALU_LAT-1];
`ifdef ALU_FEED_TAG_EN
         op_p[0] <= pop ? head.op : 2'd0;
         for (int i = 1; i < ALU_LAT; i++) op_p[i] <= op_p[i-1];
         res_op  <= op_p[ALU_LAT-1];
`endif
         if (pop) begin
            alu_a  <= head.a;
            alu_b  <= head.b;
            alu_op <= head.op;
         end
         unique case (state)
            ST_IDLE:  if (enable && count != '0) state <= ST_RUN;
            ST_RUN:   if (!enable || cnt_nxt == '0) state <= ST_DRAIN;
            ST_DRAIN: begin
               if (enable && count != '0) state <= ST_RUN;
               else if (tag_nxt == '0)    state <= ST_IDLE;
            end
            default:  state <= ST_IDLE;
         endcase
      end
   end

   assign res_data = alu_res;
   assign busy     = (state != ST_IDLE);

endmodule

// File: tb/tb_alu_cmd_feeder.sv
// Bench for alu_cmd_feeder driving a behavioural 2-stage ALU; results are
// scored against an in-order command queue evaluated with plain arithmetic.
module tb_alu_cmd_feeder;
   import alu_pkg::*;

   localparam int DEPTH  = 8;
   localparam int ADDR_W = 3;

   logic             clk = 1'b0;
   logic             rst;
   logic             flush;
   logic             enable;
   logic [3:0]       alu_a;
   logic [3:0]       alu_b;
   logic [1:0]       alu_op;
   logic [7:0]       alu_res;
   logic             res_valid;
   logic [7:0]       res_data;
   logic [1:0]       res_op;
   logic [ADDR_W:0]  count;
   logic             busy;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   logic [9:0] exp_q [$];
   logic [9:0] obs_q [$];
   int         obs_cyc [$];

   alu_cmd_feeder_if in_if ();

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   alu_cmd_feeder #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .ALU_LAT(2)) dut (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .enable    (enable),
      .in_if     (in_if),
      .alu_a     (alu_a),
      .alu_b     (alu_b),
      .alu_op    (alu_op),
      .alu_res   (alu_res),
      .res_valid (res_valid),
      .res_data  (res_data),
`ifdef ALU_FEED_TAG_EN
      .res_op    (res_op),
`endif
      .count     (count),
      .busy      (busy)
   );

`ifndef ALU_FEED_TAG_EN
   assign res_op = 2'd0;
`endif

   // Behavioural alu_seq: input register stage, then result register stage.
   logic [3:0] sa, sb;
   logic [1:0] sop;
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sa <= '0; sb <= '0; sop <= '0; alu_res <= '0;
      end else begin
         sa <= alu_a; sb <= alu_b; sop <= alu_op;
         case (sop)
            2'd0: alu_res <= {4'd0, sa} + {4'd0, sb};
            2'd1: alu_res <= {4'd0, sa} * {4'd0, sb};
            2'd2: alu_res <= {4'd0, sa} - {4'd0, sb};
            default: alu_res <= {4'd0, sa & sb};
         endcase
      end
   end

   always @(negedge clk) begin
      if (!rst && res_valid) begin
         obs_q.push_back({res_op, res_data});
         obs_cyc.push_back(cyc);
      end
   end

   // Reference: expected {op, result} of a command word {op, a, b}.
   function automatic logic [9:0] ref_res(input logic [9:0] c);
      int a, b, r;
      a = int'(c[7:4]);
      b = int'(c[3:0]);
      case (c[9:8])
         2'd0: r = a + b;
         2'd1: r = a * b;
         2'd2: r = (a - b + 256) % 256;
         default: r = a & b;
      endcase
`ifdef ALU_FEED_TAG_EN
      return {c[9:8], r[7:0]};
`else
      return {2'b00, r[7:0]};
`endif
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_model();
      exp_q.delete();
      obs_q.delete();
      obs_cyc.delete();
   endtask

   task automatic offer(input logic [9:0] c, output bit ok);
      ok = 1'b0;
      in_if.in_valid = 1'b1;
      in_if.in_op = c[9:8];
      in_if.in_a  = c[7:4];
      in_if.in_b  = c[3:0];
      for (int i = 0; i < 64; i++) begin
         if (in_if.in_ready) begin
            exp_q.push_back(c);
            tick();
            ok = 1'b1;
            break;
         end
         tick();
      end
      in_if.in_valid = 1'b0;
   endtask

   task automatic wait_idle(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 300; i++) begin
         if (!busy && count == '0) begin
            ok = 1'b1;
            break;
         end
         tick();
      end
      repeat (3) tick();
   endtask

   task automatic test_reset();
      rst = 1'b1; flush = 1'b0; enable = 1'b0;
      in_if.in_valid = 1'b0; in_if.in_a = '0; in_if.in_b = '0; in_if.in_op = '0;
      repeat (3) tick();
      rst = 1'b0;
      tick();
      checks++; if (count !== '0) begin errors++; $display("FAIL reset_count got %0d want 0", count); end
      checks++; if (in_if.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_if.in_ready); end
      checks++; if ({alu_op, alu_a, alu_b} !== 10'd0) begin errors++; $display("FAIL reset_alu got %h want 0", {alu_op, alu_a, alu_b}); end
      checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL reset_res_valid got %b want 0", res_valid); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
   endtask

   task automatic test_single();
      bit ok;
      int n;
      clear_model();
      enable = 1'b1;
      offer(10'h035, ok);
      checks++; if (!ok) begin errors++; $display("FAIL single_push got timeout want accepted"); end
      n = 0;
      while (alu_a !== 4'd3 && n < 10) begin tick(); n++; end
      checks++; if (n !== 2) begin errors++; $display("FAIL single_issue_edge got %0d want 2", n); end
      checks++; if (alu_b !== 4'd5) begin errors++; $display("FAIL single_alu_b got %0d want 5", alu_b); end
      checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL single_early0 got %b want 0", res_valid); end
      tick();
      checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL single_early1 got %b want 0", res_valid); end
      tick();
      checks++; if (res_valid !== 1'b1 || res_data !== 8'd8) begin errors++; $display("FAIL single_result got v=%b d=%0d want v=1 d=8", res_valid, res_data); end
      tick();
      checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL single_pulse_end got %b want 0", res_valid); end
      repeat (3) tick();
      checks++; if (obs_q.size() !== 1) begin errors++; $display("FAIL single_pulse_count got %0d want 1", obs_q.size()); end
   endtask

   task automatic test_burst();
      bit ok, all_ok, seen;
      int busy_fall;
      logic [9:0] cmds [4];
      int exp_d [4];
      int exp_o [4];
      cmds = '{10'h127, 10'h294, 10'h3FA, 10'h0FF};
      exp_d = '{14, 5, 10, 30};
      exp_o = '{1, 2, 3, 0};
      clear_model();
      enable = 1'b1;
      all_ok = 1'b1;
      for (int i = 0; i < 4; i++) begin offer(cmds[i], ok); all_ok &= ok; end
      checks++; if (!all_ok) begin errors++; $display("FAIL burst_push got timeout want accepted"); end
      seen = 1'b0; busy_fall = -1;
      for (int i = 0; i < 40; i++) begin
         if (busy) seen = 1'b1;
         else if (seen && busy_fall < 0) busy_fall = cyc;
         tick();
      end
      checks++; if (obs_q.size() !== 4) begin errors++; $display("FAIL burst_count got %0d want 4", obs_q.size()); end
      for (int i = 0; i < 4 && i < obs_q.size(); i++) begin
         checks++; if (int'(obs_q[i][7:0]) !== exp_d[i]) begin errors++; $display("FAIL burst_data[%0d] got %0d want %0d", i, obs_q[i][7:0], exp_d[i]); end
         checks++; if (obs_q[i] !== ref_res(exp_q[i])) begin errors++; $display("FAIL burst_model[%0d] got %h want %h", i, obs_q[i], ref_res(exp_q[i])); end
         checks++; if (obs_cyc[i] !== obs_cyc[0] + i) begin errors++; $display("FAIL burst_b2b[%0d] got %0d want %0d", i, obs_cyc[i], obs_cyc[0] + i); end
`ifdef ALU_FEED_TAG_EN
         checks++; if (int'(obs_q[i][9:8]) !== exp_o[i]) begin errors++; $display("FAIL burst_res_op[%0d] got %0d want %0d", i, obs_q[i][9:8], exp_o[i]); end
`endif
      end
      if (obs_q.size() == 4) begin
         checks++; if (busy_fall !== obs_cyc[3]) begin errors++; $display("FAIL burst_busy_drop got %0d want %0d", busy_fall, obs_cyc[3]); end
      end
   endtask

   task automatic test_backpressure();
      bit ok, all_ok;
      int n;
      logic [9:0] c;
      logic [ADDR_W:0] cnt_acc;
      clear_model();
      enable = 1'b0;
      all_ok = 1'b1;
      for (int i = 0; i < 8; i++) begin c = 10'($urandom); offer(c, ok); all_ok &= ok; end
      checks++; if (!all_ok) begin errors++; $display("FAIL bp_fill got timeout want accepted"); end
      checks++; if (count !== 4'd8 || in_if.in_ready !== 1'b0) begin errors++; $display("FAIL bp_full got cnt=%0d rdy=%b want cnt=8 rdy=0", count, in_if.in_ready); end
      c = 10'($urandom);
      in_if.in_valid = 1'b1; in_if.in_op = c[9:8]; in_if.in_a = c[7:4]; in_if.in_b = c[3:0];
      repeat (3) tick();
      checks++; if (count !== 4'd8 || busy !== 1'b0) begin errors++; $display("FAIL bp_hold got cnt=%0d busy=%b want cnt=8 busy=0", count, busy); end
      enable = 1'b1;
      n = 0;
      while (!in_if.in_ready && n < 20) begin tick(); n++; end
      cnt_acc = count;
      exp_q.push_back(c);
      tick();
      in_if.in_valid = 1'b0;
      checks++; if (n !== 2 || cnt_acc !== 4'd7) begin errors++; $display("FAIL bp_accept got n=%0d cnt=%0d want n=2 cnt=7", n, cnt_acc); end
      wait_idle(ok);
      checks++; if (!ok) begin errors++; $display("FAIL bp_drain got timeout want idle"); end
      checks++; if (obs_q.size() !== 9) begin errors++; $display("FAIL bp_count got %0d want 9", obs_q.size()); end
      for (int i = 0; i < 9 && i < obs_q.size(); i++) begin
         checks++; if (obs_q[i] !== ref_res(exp_q[i])) begin errors++; $display("FAIL bp_order[%0d] got %h want %h", i, obs_q[i], ref_res(exp_q[i])); end
      end
   endtask

   task automatic test_flush();
      bit ok;
      logic [9:0] c [3];
      clear_model();
      enable = 1'b1;
      for (int i = 0; i < 3; i++) c[i] = {2'($urandom), 4'($urandom_range(1, 15)), 4'($urandom)};
      for (int i = 0; i < 3; i++) begin
         in_if.in_valid = 1'b1; in_if.in_op = c[i][9:8]; in_if.in_a = c[i][7:4]; in_if.in_b = c[i][3:0];
         tick();
      end
      in_if.in_valid = 1'b0;
      tick();
      flush = 1'b1;
      tick();
      flush = 1'b0;
      checks++; if (count !== '0 || busy !== 1'b0) begin errors++; $display("FAIL flush_state got cnt=%0d busy=%b want cnt=0 busy=0", count, busy); end
      checks++; if (in_if.in_ready !== 1'b1) begin errors++; $display("FAIL flush_ready got %b want 1", in_if.in_ready); end
      checks++; if ({alu_a, alu_b} !== c[1][7:0]) begin errors++; $display("FAIL flush_alu_hold got %h want %h", {alu_a, alu_b}, c[1][7:0]); end
      repeat (6) tick();
      checks++; if (obs_q.size() !== 0) begin errors++; $display("FAIL flush_discard got %0d pulses want 0", obs_q.size()); end
      wait_idle(ok);
      checks++; if (!ok) begin errors++; $display("FAIL flush_idle got busy want idle"); end
   endtask

   task automatic test_enable_toggle();
      bit ok, acc;
      int sent;
      logic [9:0] c;
      clear_model();
      sent = 0;
      for (int t = 0; t < 3000 && sent < 30; t++) begin
         enable = ($urandom_range(0, 3) != 0);
         if (!in_if.in_valid && $urandom_range(0, 2) != 0) begin
            c = 10'($urandom);
            in_if.in_valid = 1'b1; in_if.in_op = c[9:8]; in_if.in_a = c[7:4]; in_if.in_b = c[3:0];
         end
         acc = in_if.in_valid && in_if.in_ready;
         if (acc) exp_q.push_back({in_if.in_op, in_if.in_a, in_if.in_b});
         tick();
         if (acc) begin in_if.in_valid = 1'b0; sent++; end
      end
      in_if.in_valid = 1'b0;
      enable = 1'b1;
      wait_idle(ok);
      checks++; if (!ok || sent !== 30) begin errors++; $display("FAIL rand_drain got ok=%b sent=%0d want ok=1 sent=30", ok, sent); end
      checks++; if (obs_q.size() !== exp_q.size()) begin errors++; $display("FAIL rand_count got %0d want %0d", obs_q.size(), exp_q.size()); end
      for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
         checks++; if (obs_q[i] !== ref_res(exp_q[i])) begin errors++; $display("FAIL rand_res[%0d] got %h want %h", i, obs_q[i], ref_res(exp_q[i])); end
      end
   endtask

   task automatic test_async_reset();
      bit ok, all_ok;
      clear_model();
      enable = 1'b1;
      all_ok = 1'b1;
      for (int i = 0; i < 5; i++) begin
         offer({2'($urandom), 4'($urandom_range(1, 15)), 4'($urandom_range(1, 15))}, ok);
         all_ok &= ok;
      end
      checks++; if (!all_ok) begin errors++; $display("FAIL arst_push got timeout want accepted"); end
      #2;
      rst = 1'b1;
      #1;
      checks++; if ({alu_op, alu_a, alu_b} !== 10'd0) begin errors++; $display("FAIL arst_alu got %h want 0", {alu_op, alu_a, alu_b}); end
      checks++; if (count !== '0 || busy !== 1'b0 || res_valid !== 1'b0) begin errors++; $display("FAIL arst_ctrl got cnt=%0d busy=%b v=%b want 0 0 0", count, busy, res_valid); end
      checks++; if (res_op !== 2'd0 || in_if.in_ready !== 1'b1) begin errors++; $display("FAIL arst_misc got op=%0d rdy=%b want op=0 rdy=1", res_op, in_if.in_ready); end
      obs_q.delete();
      tick();
      rst = 1'b0;
      repeat (6) tick();
      checks++; if (obs_q.size() !== 0 || count !== '0) begin errors++; $display("FAIL arst_lost got pulses=%0d cnt=%0d want 0 0", obs_q.size(), count); end
   endtask

   initial begin
      rst = 1'b1;
      test_reset();
      test_single();
      test_burst();
      test_backpressure();
      test_flush();
      test_enable_toggle();
      test_async_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog got timeout want finish");
      $fatal(1, "watchdog");
   end

endmodule
